// File: rtl/adder_arb_pkg.sv
// Shared constants, slot state and round-robin helper for the adder_arbiter block.
package adder_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt_id   = idx;
                gnt[idx] = en;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH-bit adder between N_REQ requesters through a single result slot.
//   state | meaning
//   EMPTY | no result held; a request may be accepted
//   FULL  | result held on rsp_*; drains when rsp_ready is high
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_op1,
    input  logic [N_REQ*WIDTH-1:0] req_op2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
    output logic [ID_W-1:0]        rsp_id
);

    slot_state_t      state_q, state_d;
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] op1_sel, op2_sel;
    logic [WIDTH:0]   add_res;

    assign free = (state_q == EMPTY) || rsp_ready;

    // Reset blanks the grant so nothing is accepted while the slot is being cleared.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (free && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign rsp_valid = (state_q == FULL);

    assign op1_sel = req_op1[int'(gnt_id)*WIDTH +: WIDTH];
    assign op2_sel = req_op2[int'(gnt_id)*WIDTH +: WIDTH];
    assign add_res = {1'b0, op1_sel} + {1'b0, op2_sel};

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = FULL;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else if (xfer) begin
            ptr_q     <= ID_W'(rr_next(32'(gnt_id), N_REQ));
            rsp_sum   <= add_res[WIDTH-1:0];
            rsp_carry <= add_res[WIDTH];
            rsp_id    <= gnt_id;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vectors, corner sequences, random vs. model.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_op1, req_op2;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic [1:0]     rsp_id;

    int total = 0;
    int bad   = 0;

    adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } vec_t;

    vec_t vecs[6];

    // Reference model state for the random phase.
    int          m_ptr;
    bit          m_full;
    logic [32:0] m_res;
    int          m_id;
    bit          pend[N];
    logic [31:0] pa[N], pb[N];

    initial begin
        vecs[0] = '{2, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
        vecs[2] = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};

        req_op1 = '0;
        req_op2 = '0;
        reset_dut();

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_carry", 64'(rsp_carry), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);

        // Single-requester vectors
        rsp_ready = 1'b1;
        foreach (vecs[v]) begin
            tick();
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_op1[vecs[v].id*W +: W] = vecs[v].a;
            req_op2[vecs[v].id*W +: W] = vecs[v].b;
            @(negedge clk);
            check("vec_ready", 64'(req_ready), 64'(4'b0001 << vecs[v].id));
            tick();
            req_valid = '0;
            @(negedge clk);
            check("vec_valid", 64'(rsp_valid), 64'd1);
            check("vec_sum", 64'(rsp_sum), 64'(vecs[v].sum));
            check("vec_carry", 64'(rsp_carry), 64'(vecs[v].carry));
            check("vec_id", 64'(rsp_id), 64'(vecs[v].id));
        end

        // Fairness: all valid, back-to-back results rotating from 0
        reset_dut();
        for (int i = 0; i < N; i++) begin
            req_op1[i*W +: W] = 32'(i * 100);
            req_op2[i*W +: W] = 32'(i + 1);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("fair_valid", 64'(rsp_valid), 64'd1);
                check("fair_id", 64'(rsp_id), 64'((k - 1) % N));
                check("fair_sum", 64'(rsp_sum), 64'(((k - 1) % N) * 101 + 1));
            end
        end

        // Backpressure: id 1 held, then 3 wins over 0 because ptr = 2
        tick();
        reset_dut();
        req_valid = 4'b0010;
        req_op1[1*W +: W] = 32'd3;
        req_op2[1*W +: W] = 32'd4;
        req_op1[0*W +: W] = 32'd10;
        req_op2[0*W +: W] = 32'd20;
        req_op1[3*W +: W] = 32'hFFFF_FFF0;
        req_op2[3*W +: W] = 32'h0000_0020;
        @(negedge clk);
        check("bp_first_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall_ready", 64'(req_ready), 64'd0);
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_id", 64'(rsp_id), 64'd1);
            check("bp_hold_sum", 64'(rsp_sum), 64'd7);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req_ready), 64'(4'b1000));
        tick();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_next_id", 64'(rsp_id), 64'd3);
        check("bp_next_sum", 64'(rsp_sum), 64'h10);
        check("bp_next_carry", 64'(rsp_carry), 64'd1);

        // Reset while FULL discards the result and restores ptr = 0
        tick();
        rst = 1'b1;
        req_valid = 4'b0011;
        @(negedge clk);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_after_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("mid_after_id", 64'(rsp_id), 64'd0);
        check("mid_after_sum", 64'(rsp_sum), 64'd30);

        // Random traffic against a queue-style model
        tick();
        reset_dut();
        m_ptr  = 0;
        m_full = 0;
        m_res  = '0;
        m_id   = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int win;
            bit free;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    pb[i] = $urandom;
                end
                req_valid[i] = pend[i];
                req_op1[i*W +: W] = pa[i];
                req_op2[i*W +: W] = pb[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            free = !m_full || rsp_ready;
            win  = -1;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (win < 0 && pend[j]) win = j;
                end
            end
            check("rnd_ready", 64'(req_ready), (win >= 0) ? 64'(4'b0001 << win) : 64'd0);
            check("rnd_valid", 64'(rsp_valid), 64'(m_full));
            if (m_full) begin
                check("rnd_result", {31'd0, rsp_carry, rsp_sum}, 64'(m_res));
                check("rnd_id", 64'(rsp_id), 64'(m_id));
            end
            if (win >= 0) begin
                m_res     = 33'(64'(pa[win]) + 64'(pb[win]));
                m_id      = win;
                m_full    = 1;
                m_ptr     = (win + 1) % N;
                pend[win] = 0;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one 32-bit two-operand adder between N_REQ independent requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter grants one request per cycle into a single registered result slot, and the slot returns the sum, carry and requester ID over a valid/ready response port. The block sits between the execution-side clients and the shared adder datapath, so that no client needs its own adder.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `WIDTH`, 32 — operand and sum width.
- `ID_W`, $clog2(N_REQ) — width of the requester ID.

- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `req_valid`  in  N_REQ  — request i presents operands.
- `req_ready`  out  N_REQ  — request i is accepted this cycle (one-hot or zero).
- `req_op1`  in  N_REQ*WIDTH  — first operand; requester i uses slice [i*WIDTH +: WIDTH].
- `req_op2`  in  N_REQ*WIDTH  — second operand; same slicing as `req_op1`.
- `rsp_valid`  out  1  — the result slot is full.
- `rsp_ready`  in  1  — the consumer takes the result this cycle.
- `rsp_sum`  out  WIDTH  — (op1 + op2) mod 2^WIDTH.
- `rsp_carry`  out  1  — carry out of bit WIDTH-1.
- `rsp_id`  out  ID_W  — index of the requester that owns the result.

## Operation
- **Slot state machine** has two states, EMPTY and FULL.
  - `rsp_valid` = (state == FULL).
  - `free` = EMPTY | (FULL & `rsp_ready`).
- **Arbitration**
  - Arbitration is combinational over `req_valid`.
  - The search starts at `ptr`, then goes `ptr`+1, and so on, wrapping at N_REQ-1 → 0.
  - The first valid requester found is the winner.
- **Acceptance**
  - `req_ready[w]` = `free` & `req_valid[w]`.
  - All other `req_ready` bits are 0.
  - A transfer happens when `req_valid[i]` & `req_ready[i]` are both high.
- **On a transfer**
  - `{rsp_carry, rsp_sum}` <= {1'b0, op1} + {1'b0, op2}, computed as a single (WIDTH+1)-bit add.
  - `rsp_id` <= w.
  - State <= FULL.
  - `ptr` <= (w+1) mod N_REQ.
- **No transfer, FULL & `rsp_ready`:** state <= EMPTY.
- **No transfer, any other case:** state, data and `ptr` hold.
- **`ptr` update:** `ptr` changes only on a transfer. A stall or an idle cycle never moves priority.
- **Requester obligations**
  - Hold `req_valid` and the operands stable until `req_ready` is asserted.
  - The arbiter does not register requests.
- **Response hold:** while FULL & !`rsp_ready`, the values of `rsp_sum`, `rsp_carry` and `rsp_id` hold stable.

## Timing
- **Reset values** (applied at the first rising edge with `rst` = 1):
  - state = EMPTY, so `rsp_valid` = 0.
  - `ptr` = 0.
  - `rsp_sum` = 0, `rsp_carry` = 0, `rsp_id` = 0.
  - `req_ready` is 0 while `rst` is high.
- **Reset mid-operation:** any held result is discarded. No response is produced for it.
- **Latency:** an accept at cycle t gives `rsp_valid` at cycle t+1.
- **Throughput:** one result per cycle when `rsp_ready` is held high. The drain and the new accept happen on the same edge.
- **Backpressure:** FULL & !`rsp_ready` forces every `req_ready` bit to 0.
- **Simultaneous events**
  - When all requesters are valid, grants rotate ptr, ptr+1, and so on. No requester waits more than N_REQ-1 grants.
  - `rsp_ready` asserted while EMPTY is ignored.
- **Wrap-around:** the sum wraps modulo 2^WIDTH. The carry captures the overflow.
- **Combinational paths:**
  - `req_ready` depends on `req_valid`, `ptr`, state and `rsp_ready`.
  - No combinational path exists from `req_op*` to any output.

## Structure
- **Package `adder_arb_pkg`** holds:
  - the default constants for `N_REQ` and `WIDTH`;
  - the slot state enum (EMPTY, FULL);
  - a helper function `rr_next(ptr, n)` that returns (ptr+1) mod n.
- **Sub-module `rr_arbiter`**
  - Parameter: `N`.
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt[N]` (one-hot) and `gnt_id`.
  - Purely combinational.
  - The top level owns `ptr`, the slot register and the adder.

## Test plan
- **Reset:** hold `rst` for 2 cycles, then release with all inputs idle → `rsp_valid` = 0, `req_ready` = 0, `ptr` = 0, and outputs all zero.
- **Single request:** only requester 2 valid with op1 = 32'h0000_0005, op2 = 32'h0000_0007, and `rsp_ready` = 1 → `req_ready` = 4'b0100 in the same cycle. Next cycle shows `rsp_valid` = 1, sum = 12, carry = 0, id = 2.
- **Overflow:** op1 = 32'hFFFF_FFFF, op2 = 32'h0000_0002 → sum = 32'h0000_0001, carry = 1.
- **Fairness:** all 4 requesters valid continuously and `rsp_ready` = 1 → `rsp_id` sequence is 0, 1, 2, 3, 0, 1, with one result per cycle and no gaps.
- **Backpressure:** result for id 1 held with `rsp_ready` = 0 for 3 cycles while requesters 0 and 3 are valid → `req_ready` = 0 and the result stays stable. On the `rsp_ready` cycle, requester 3 is granted, not requester 0, since `ptr` = 2.
- **Reset mid-operation:** assert `rst` while FULL → next cycle `rsp_valid` = 0. After reset release with requesters 1 and 0 valid, requester 0 is granted first.
